nibble_serial_adder_ctrl: RTL



---
 rtl/nibble_serial_adder_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Purpose:
//   Computes a WIDTH-bit add or subtract by reusing one SLICE-bit
//   carry-lookahead slice. The operands are processed one slice per cycle,
//   least-significant slice first. The inter-slice carry is held in a register.
//   Subtract is formed as A + ~B + 1. The +1 enters as the initial carry.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request valid from the issuing unit
//   in_ready   controller is idle and can take a request
//   in_a       operand A
//   in_b       operand B
//   in_sub     1 = A-B, 0 = A+B
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_sum    result, modulo 2^WIDTH
//   out_cout   carry out of the MSB (for subtract: 1 = no borrow)
//   out_ovf    signed two's-complement overflow
//   busy       an operation is running or its result is waiting
// ----------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Generate/propagate slice. The carry recurrence is written as a loop,
  // and synthesis flattens it into lookahead terms: c[i+1] = g[i] | p[i]&c[i].
  function automatic logic [SLICE:0] cla_slice(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             cin
  );
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  logic [31:0]      slice_lo_s;
  logic [SLICE:0]   slice_res_s;

  // Slice datapath plus next-state logic. The status outputs are decoded from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;

    slice_lo_s  = 32'(cnt_q) * 32'(SLICE);
    slice_res_s = cla_slice(a_q[slice_lo_s +: SLICE], b_q[slice_lo_s +: SLICE], carry_q);

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d       = in_a;
          b_d       = in_sub ? ~in_b : in_b;
          carry_d   = in_sub;
          cnt_d     = {CW{1'b0}};
          out_sum_d = {WIDTH{1'b0}};
          state_d   = ST_RUN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_RUN: begin
        out_sum_d[slice_lo_s +: SLICE] = slice_res_s[SLICE-1:0];
        carry_d = slice_res_s[SLICE];
        if (cnt_q == CW'(N - 1)) begin
          // The last slice supplies the final carry and the result MSB used for overflow.
          out_cout_d = slice_res_s[SLICE];
          out_ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (slice_res_s[SLICE-1] != a_q[WIDTH-1]);
          cnt_d      = {CW{1'b0}};
          state_d    = ST_DONE;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          state_d    = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  // State, datapath and registered status flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      carry_q     <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      out_sum_q   <= {WIDTH{1'b0}};
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule
